// File: rtl/cva6_tlb_sv32_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cva6_tlb_sv32_pkg
// Brief    : Tag layout, widths and update_i field offsets shared by the Sv32
//            TLB. Build macro CVA6_TLB_PLRU_EN selects pseudo-LRU replacement.
// Revision : 1.0 - initial release
// ============================================================================
package cva6_tlb_sv32_pkg;

   localparam int c_tag_w     = 31;
   localparam int c_content_w = 32;
   localparam int c_upd_w     = 63;

   localparam int c_upd_valid   = 62;
   localparam int c_upd_is_4m   = 61;
   localparam int c_upd_vpn1_hi = 60;
   localparam int c_upd_vpn1_lo = 51;
   localparam int c_upd_vpn0_hi = 50;
   localparam int c_upd_vpn0_lo = 41;
   localparam int c_upd_asid_hi = 40;
   localparam int c_upd_asid_lo = 32;
   localparam int c_upd_pte_hi  = 31;
   localparam int c_upd_pte_lo  = 0;

   typedef struct packed {
      logic [8:0] asid;
      logic [9:0] vpn1;
      logic [9:0] vpn0;
      logic       is_4M;
      logic       valid;
   } tlb_tag_t;

endpackage
`default_nettype wire

// File: rtl/cva6_tlb_sv32_plru.sv
`default_nettype none
// ============================================================================
// Module   : tlb_plru_tree
// Brief    : Binary-tree pseudo-LRU over ENTRIES leaves (ENTRIES-1 node bits).
//            Used by cva6_tlb_sv32 when CVA6_TLB_PLRU_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tlb_plru_tree #(
   parameter int ENTRIES = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_touch_valid,
   input  logic [$clog2(ENTRIES)-1:0] i_touch_idx,
   output logic [$clog2(ENTRIES)-1:0] o_victim_idx
);

   localparam int c_idx_w = $clog2(ENTRIES);

   // Node n of level l sits at heap index 2**l-1+p; a set bit steers the victim right.
   logic [ENTRIES-2:0] r_tree;
   logic [ENTRIES-2:0] w_tree_nxt;
   logic [c_idx_w-1:0] w_victim;

   always_comb begin
      w_tree_nxt = r_tree;
      if (i_touch_valid) begin
         for (int l = 0; l < c_idx_w; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
               if (int'(i_touch_idx >> (c_idx_w - l)) == p) begin
                  w_tree_nxt[(1 << l) - 1 + p] = ~i_touch_idx[c_idx_w - 1 - l];
               end
            end
         end
      end
   end

   always_comb begin
      w_victim = '0;
      for (int l = 0; l < c_idx_w; l++) begin
         for (int p = 0; p < (1 << l); p++) begin
            if ((int'(w_victim >> (c_idx_w - l)) == p) && r_tree[(1 << l) - 1 + p]) begin
               w_victim[c_idx_w - 1 - l] = 1'b1;
            end
         end
      end
   end

   assign o_victim_idx = w_victim;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tree <= '0;
      end else begin
         r_tree <= w_tree_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/cva6_tlb_sv32.sv
`default_nettype none
// ============================================================================
// Module   : cva6_tlb_sv32
// Brief    : Fully-associative Sv32 TLB with 4 MiB superpages, filtered flush
//            and round-robin replacement (pseudo-LRU with CVA6_TLB_PLRU_EN).
// Revision : 1.0 - initial release
// ============================================================================
module cva6_tlb_sv32
   import cva6_tlb_sv32_pkg::*;
#(
   parameter int TLB_ENTRIES = 4,
   parameter int ASID_WIDTH  = 1
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                flush_i,
   input  logic [c_upd_w-1:0]                  update_i,
   input  logic                                lu_access_i,
   input  logic [ASID_WIDTH-1:0]               lu_asid_i,
   input  logic [31:0]                         lu_vaddr_i,
   input  logic [ASID_WIDTH-1:0]               asid_to_be_flushed_i,
   input  logic [31:0]                         vaddr_to_be_flushed_i,
   output logic [c_content_w-1:0]              lu_content_o,
   output logic                                lu_is_4M_o,
   output logic                                lu_hit_o,
   output logic [TLB_ENTRIES*c_content_w-1:0]  port_content_q_o,
   output logic [TLB_ENTRIES*c_tag_w-1:0]      port_tags_q_o
);

   localparam int c_idx_w = $clog2(TLB_ENTRIES);

   tlb_tag_t               r_tags    [TLB_ENTRIES];
   logic [c_content_w-1:0] r_content [TLB_ENTRIES];

   logic [TLB_ENTRIES-1:0] w_hit;
   logic [TLB_ENTRIES-1:0] w_flush_match;
   logic                   w_hit_any;
   logic                   w_all_valid;
   logic                   w_upd_we;
   logic                   w_flush_asid_any;
   logic                   w_flush_vaddr_any;
   logic [c_idx_w-1:0]     w_hit_idx;
   logic [c_idx_w-1:0]     w_free_idx;
   logic [c_idx_w-1:0]     w_policy_idx;
   logic [c_idx_w-1:0]     w_victim_idx;
   tlb_tag_t               w_new_tag;
   logic                   w_unused;

   assign w_flush_asid_any  = (asid_to_be_flushed_i == '0);
   assign w_flush_vaddr_any = (vaddr_to_be_flushed_i == '0);
   assign w_upd_we          = update_i[c_upd_valid] & ~flush_i;

   assign w_new_tag = {update_i[c_upd_asid_hi:c_upd_asid_lo],
                       update_i[c_upd_vpn1_hi:c_upd_vpn1_lo],
                       update_i[c_upd_vpn0_hi:c_upd_vpn0_lo],
                       update_i[c_upd_is_4m],
                       1'b1};

   // A zero filter is a wildcard, so the four flush modes collapse to one AND of two terms.
   always_comb begin
      w_hit         = '0;
      w_flush_match = '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         w_hit[i] = r_tags[i].valid
                 && (r_tags[i].asid[ASID_WIDTH-1:0] == lu_asid_i)
                 && (r_tags[i].vpn1 == lu_vaddr_i[31:22])
                 && (r_tags[i].is_4M || (r_tags[i].vpn0 == lu_vaddr_i[21:12]));
         w_flush_match[i] =
              (w_flush_asid_any || (r_tags[i].asid[ASID_WIDTH-1:0] == asid_to_be_flushed_i))
           && (w_flush_vaddr_any
               || ((r_tags[i].vpn1 == vaddr_to_be_flushed_i[31:22])
                   && (r_tags[i].is_4M || (r_tags[i].vpn0 == vaddr_to_be_flushed_i[21:12]))));
      end
   end

   // Descending scan so the lowest-index hit is the last one written.
   always_comb begin
      w_hit_any    = 1'b0;
      w_hit_idx    = '0;
      lu_content_o = '0;
      lu_is_4M_o   = 1'b0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            w_hit_any    = 1'b1;
            w_hit_idx    = i[c_idx_w-1:0];
            lu_content_o = r_content[i];
            lu_is_4M_o   = r_tags[i].is_4M;
         end
      end
   end

   assign lu_hit_o = w_hit_any;

   always_comb begin
      w_all_valid = 1'b1;
      w_free_idx  = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (!r_tags[i].valid) begin
            w_all_valid = 1'b0;
            w_free_idx  = i[c_idx_w-1:0];
         end
      end
   end

   assign w_victim_idx = w_all_valid ? w_policy_idx : w_free_idx;

`ifdef CVA6_TLB_PLRU_EN
   logic               w_touch_valid;
   logic [c_idx_w-1:0] w_touch_idx;

   // A write and a hit lookup in the same cycle: the write is the more recent use.
   assign w_touch_valid = w_upd_we | (lu_access_i & w_hit_any);
   assign w_touch_idx   = w_upd_we ? w_victim_idx : w_hit_idx;

   tlb_plru_tree #(
      .ENTRIES (TLB_ENTRIES)
   ) u_plru (
      .clk           (clk_i),
      .rst           (rst_i),
      .i_touch_valid (w_touch_valid),
      .i_touch_idx   (w_touch_idx),
      .o_victim_idx  (w_policy_idx)
   );
`else
   logic [c_idx_w-1:0] r_rr_ptr;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_rr_ptr <= '0;
      end else if (w_upd_we && w_all_valid) begin
         r_rr_ptr <= r_rr_ptr + c_idx_w'(1);
      end
   end

   assign w_policy_idx = r_rr_ptr;
`endif

   assign w_unused = ^{lu_access_i, lu_vaddr_i[11:0], w_hit_idx};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            r_tags[i]    <= '0;
            r_content[i] <= '0;
         end
      end else if (flush_i) begin
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (w_flush_match[i]) begin
               r_tags[i].valid <= 1'b0;
            end
         end
      end else if (w_upd_we) begin
         for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (w_victim_idx == i[c_idx_w-1:0]) begin
               r_tags[i]    <= w_new_tag;
               r_content[i] <= update_i[c_upd_pte_hi:c_upd_pte_lo];
            end
         end
      end
   end

   for (genvar g = 0; g < TLB_ENTRIES; g++) begin : g_port
      assign port_tags_q_o[g*c_tag_w +: c_tag_w]            = r_tags[g];
      assign port_content_q_o[g*c_content_w +: c_content_w] = r_content[g];
   end

endmodule
`default_nettype wire

// File: tb/tb_cva6_tlb_sv32.sv
`default_nettype none
// ============================================================================
// Module   : tb_cva6_tlb_sv32
// Brief    : Directed self-checking bench for cva6_tlb_sv32 (4 entries, 1 ASID
//            bit); replacement expectation follows CVA6_TLB_PLRU_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cva6_tlb_sv32;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         flush_i;
   logic [62:0]  update_i;
   logic         lu_access_i;
   logic [0:0]   lu_asid_i;
   logic [31:0]  lu_vaddr_i;
   logic [0:0]   asid_to_be_flushed_i;
   logic [31:0]  vaddr_to_be_flushed_i;
   logic [31:0]  lu_content_o;
   logic         lu_is_4M_o;
   logic         lu_hit_o;
   logic [127:0] port_content_q_o;
   logic [123:0] port_tags_q_o;

   int checks = 0;
   int errors = 0;

   cva6_tlb_sv32 #(
      .TLB_ENTRIES (4),
      .ASID_WIDTH  (1)
   ) dut (
      .clk_i                 (clk_i),
      .rst_i                 (rst_i),
      .flush_i               (flush_i),
      .update_i              (update_i),
      .lu_access_i           (lu_access_i),
      .lu_asid_i             (lu_asid_i),
      .lu_vaddr_i            (lu_vaddr_i),
      .asid_to_be_flushed_i  (asid_to_be_flushed_i),
      .vaddr_to_be_flushed_i (vaddr_to_be_flushed_i),
      .lu_content_o          (lu_content_o),
      .lu_is_4M_o            (lu_is_4M_o),
      .lu_hit_o              (lu_hit_o),
      .port_content_q_o      (port_content_q_o),
      .port_tags_q_o         (port_tags_q_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_update(input logic [19:0] vpn, input logic [8:0] asid,
                            input logic [31:0] data, input logic is4m);
      update_i = {1'b1, is4m, vpn, asid, data};
      tick();
      update_i = '0;
   endtask

   task automatic do_flush(input logic [31:0] va, input logic asid);
      flush_i               = 1'b1;
      vaddr_to_be_flushed_i = va;
      asid_to_be_flushed_i  = asid;
      tick();
      flush_i               = 1'b0;
      vaddr_to_be_flushed_i = '0;
      asid_to_be_flushed_i  = '0;
   endtask

   task automatic look(input logic [31:0] va, input logic asid);
      lu_vaddr_i = va;
      lu_asid_i  = asid;
      #1;
   endtask

   logic [123:0] exp_tags;
   logic [127:0] exp_cont;

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; update_i = '0; lu_access_i = 1'b0;
      lu_asid_i = '0; lu_vaddr_i = '0;
      asid_to_be_flushed_i = '0; vaddr_to_be_flushed_i = '0;
      tick(); tick();
      rst_i = 1'b0;
      tick(); tick(); tick();

      // Reset state
      check("reset_tags", port_tags_q_o, '0);
      check("reset_content", port_content_q_o, '0);
      check("reset_hit", lu_hit_o, 0);
      check("reset_lu_content", lu_content_o, 0);
      check("reset_is4m", lu_is_4M_o, 0);

      // Single 4 KiB entry
      do_update(20'h12345, 9'd1, 32'hDEADBEEF, 1'b0);
      check("upd0_tags", port_tags_q_o, {31'h0, 31'h0, 31'h0, 31'h448D15});
      check("upd0_content", port_content_q_o, {96'h0, 32'hDEADBEEF});
      look(32'h12345000, 1'b1);
      check("lu4k_hit", lu_hit_o, 1);
      check("lu4k_content", lu_content_o, 32'hDEADBEEF);
      check("lu4k_is4m", lu_is_4M_o, 0);
      look(32'h12345000, 1'b0);
      check("lu4k_wrong_asid_hit", lu_hit_o, 0);
      check("lu4k_wrong_asid_content", lu_content_o, 0);
      look(32'h12346000, 1'b1);
      check("lu4k_wrong_vpn0_hit", lu_hit_o, 0);

      // Superpage entry lands in slot 1
      do_update(20'h12345, 9'd1, 32'hCAFE0001, 1'b1);
      check("upd1_tags", port_tags_q_o, {31'h0, 31'h0, 31'h448D17, 31'h448D15});
      look(32'h12000000, 1'b1);
      check("lu4m_hit", lu_hit_o, 1);
      check("lu4m_content", lu_content_o, 32'hCAFE0001);
      check("lu4m_is4m", lu_is_4M_o, 1);
      look(32'h12000000, 1'b0);
      check("lu4m_asid0_hit", lu_hit_o, 0);
      look(32'h12345000, 1'b1);
      check("multihit_lowest_content", lu_content_o, 32'hDEADBEEF);
      check("multihit_lowest_is4m", lu_is_4M_o, 0);

      // Fill, then exercise each flush filter
      do_update(20'h00001, 9'd0, 32'h11112222, 1'b0);
      do_update(20'h00002, 9'd0, 32'h33334444, 1'b0);
      check("fill_tags", port_tags_q_o, {31'h9, 31'h5, 31'h448D17, 31'h448D15});
      do_flush(32'h0, 1'b1);
      check("flush_asid_tags", port_tags_q_o, {31'h9, 31'h5, 31'h448D16, 31'h448D14});
      do_update(20'h00003, 9'd1, 32'h55556666, 1'b0);
      check("refill_lowest_free", port_tags_q_o, {31'h9, 31'h5, 31'h448D16, 31'h40000D});
      do_flush(32'h00002000, 1'b0);
      check("flush_vaddr_tags", port_tags_q_o, {31'h8, 31'h5, 31'h448D16, 31'h40000D});
      do_flush(32'h0, 1'b0);
      exp_tags = {31'h8, 31'h4, 31'h448D16, 31'h40000C};
      exp_cont = {32'h33334444, 32'h11112222, 32'hCAFE0001, 32'h55556666};
      check("flush_all_tags", port_tags_q_o, exp_tags);
      check("flush_all_content", port_content_q_o, exp_cont);
      look(32'h00003000, 1'b1);
      check("flush_all_miss", lu_hit_o, 0);

      // Flush and update together: update is dropped, state then holds
      flush_i  = 1'b1;
      update_i = {1'b1, 1'b0, 20'h00004, 9'd0, 32'h77778888};
      tick();
      flush_i  = 1'b0;
      update_i = '0;
      check("flush_upd_tags", port_tags_q_o, exp_tags);
      check("flush_upd_content", port_content_q_o, exp_cont);
      for (int k = 0; k < 2; k++) begin
         tick();
         check("idle_tags", port_tags_q_o, exp_tags);
         check("idle_content", port_content_q_o, exp_cont);
      end

      // Asynchronous reset takes effect before the next clock edge
      rst_i = 1'b1;
      #1;
      check("async_rst_content", port_content_q_o, '0);
      check("async_rst_tags", port_tags_q_o, '0);
      tick();
      rst_i = 1'b0;
      tick();

      // Replacement: fill, touch 3, 0, 1 by hit lookups, then a fifth write
      for (int k = 0; k < 4; k++) begin
         do_update(20'h00010 + 20'(k), 9'd0, 32'hA0 + 32'(k), 1'b0);
      end
      check("rep_fill_tags", port_tags_q_o, {31'h4D, 31'h49, 31'h45, 31'h41});
      lu_access_i = 1'b1;
      look(32'h00013000, 1'b0);
      check("touch3_content", lu_content_o, 32'hA3);
      tick();
      look(32'h00010000, 1'b0);
      check("touch0_content", lu_content_o, 32'hA0);
      tick();
      look(32'h00011000, 1'b0);
      check("touch1_content", lu_content_o, 32'hA1);
      tick();
      lu_access_i = 1'b0;
      do_update(20'h00020, 9'd0, 32'hB0, 1'b0);
`ifdef CVA6_TLB_PLRU_EN
      check("victim_tags", port_tags_q_o, {31'h4D, 31'h81, 31'h45, 31'h41});
      check("victim_content", port_content_q_o, {32'hA3, 32'hB0, 32'hA1, 32'hA0});
      look(32'h00012000, 1'b0);
`else
      check("victim_tags", port_tags_q_o, {31'h4D, 31'h49, 31'h45, 31'h81});
      check("victim_content", port_content_q_o, {32'hA3, 32'hA2, 32'hA1, 32'hB0});
      look(32'h00010000, 1'b0);
`endif
      check("evicted_miss", lu_hit_o, 0);
      look(32'h00020000, 1'b0);
      check("new_entry_content", lu_content_o, 32'hB0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
